// File: rtl/mem_arbiter_if.sv
// ============================================================================
// Module   : mem_arbiter_if
// Purpose  : Fetch, data and memory-side bus signals of the memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_arbiter_if;
  logic        IREQ;
  logic [31:0] IAD;
  logic [31:0] IDT;
  logic        ACKI_n;
  logic        MREQ;
  logic        WRITE;
  logic [1:0]  SIZE;
  logic [31:0] DAD;
  logic [31:0] DDT_w;
  logic [31:0] DDT_r;
  logic        ACKD_n;
  logic [31:0] MAD;
  logic        MREQ_m;
  logic        MWRITE;
  logic [1:0]  MSIZE;
  logic [31:0] MDO;
  logic [31:0] MDI;
  logic        MACK_n;
  logic        bus_err;
  logic        gnt_d;

  // slave: the arbiter's view; master: the requesters and memory around it
  modport slave (
    input  IREQ, IAD, MREQ, WRITE, SIZE, DAD, DDT_w, MDI, MACK_n,
    output IDT, ACKI_n, DDT_r, ACKD_n, MAD, MREQ_m, MWRITE, MSIZE, MDO,
           bus_err, gnt_d
  );

  modport master (
    output IREQ, IAD, MREQ, WRITE, SIZE, DAD, DDT_w, MDI, MACK_n,
    input  IDT, ACKI_n, DDT_r, ACKD_n, MAD, MREQ_m, MWRITE, MSIZE, MDO,
           bus_err, gnt_d
  );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Round-robin arbiter of one memory port between fetch and data.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
  parameter int TIMEOUT = 15,
  parameter int CW      = 8
) (
  input  wire logic    clk,
  input  wire logic    rst_n,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  localparam logic [CW-1:0] c_TIMEOUT = CW'(TIMEOUT);

  state_t        r_state;
  logic          r_last_d;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_mad;
  logic [1:0]    r_msize;
  logic [31:0]   r_mdo;
  logic          r_mreq;
  logic          r_mwrite;
  logic [31:0]   r_idt;
  logic [31:0]   r_ddt;
  logic          r_acki_n;
  logic          r_ackd_n;
  logic          r_bus_err;
  logic          r_gnt_d;

  logic          w_pick_d;
  logic [CW-1:0] w_cnt_next;
  logic          w_timeout;

  // On a tie the side that did not win last time is chosen
  assign w_pick_d   = bus.MREQ & (~bus.IREQ | ~r_last_d);
  assign w_cnt_next = r_cnt + CW'(1);
  assign w_timeout  = (w_cnt_next == c_TIMEOUT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_last_d  <= 1'b0;
      r_cnt     <= '0;
      r_mad     <= '0;
      r_msize   <= '0;
      r_mdo     <= '0;
      r_mreq    <= 1'b0;
      r_mwrite  <= 1'b0;
      r_idt     <= '0;
      r_ddt     <= '0;
      r_acki_n  <= 1'b1;
      r_ackd_n  <= 1'b1;
      r_bus_err <= 1'b0;
      r_gnt_d   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.IREQ || bus.MREQ) begin
            r_mad    <= w_pick_d ? bus.DAD : bus.IAD;
            r_msize  <= w_pick_d ? bus.SIZE : 2'b10;
            r_mwrite <= w_pick_d & bus.WRITE;
            r_mdo    <= w_pick_d ? bus.DDT_w : 32'h0;
            r_mreq   <= 1'b1;
            r_gnt_d  <= w_pick_d;
            r_last_d <= w_pick_d;
            r_cnt    <= '0;
            r_state  <= S_BUS;
          end
        end
        S_BUS: begin
          if (bus.MACK_n) begin
            r_cnt <= w_cnt_next;
          end
          // MACK_n still high on exit means the transfer timed out
          if (!bus.MACK_n || w_timeout) begin
            r_mreq    <= 1'b0;
            r_mwrite  <= 1'b0;
            r_bus_err <= bus.MACK_n;
            if (r_gnt_d) begin
              r_ackd_n <= 1'b0;
              if (!r_mwrite) begin
                r_ddt <= bus.MACK_n ? 32'h0 : bus.MDI;
              end
            end else begin
              r_acki_n <= 1'b0;
              r_idt    <= bus.MACK_n ? 32'h0 : bus.MDI;
            end
            r_state <= S_ACK;
          end
        end
        S_ACK: begin
          r_acki_n  <= 1'b1;
          r_ackd_n  <= 1'b1;
          r_bus_err <= 1'b0;
          r_cnt     <= '0;
          r_gnt_d   <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.MAD     = r_mad;
  assign bus.MSIZE   = r_msize;
  assign bus.MDO     = r_mdo;
  assign bus.MREQ_m  = r_mreq;
  assign bus.MWRITE  = r_mwrite;
  assign bus.IDT     = r_idt;
  assign bus.DDT_r   = r_ddt;
  assign bus.ACKI_n  = r_acki_n;
  assign bus.ACKD_n  = r_ackd_n;
  assign bus.bus_err = r_bus_err;
  assign bus.gnt_d   = r_gnt_d;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Scoreboard bench for mem_arbiter with a wait-state memory model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  typedef struct packed {
    logic        d;
    logic [31:0] data;
    logic        err;
  } ack_t;

  typedef struct packed {
    logic [31:0] mad;
    logic        mw;
    logic [1:0]  sz;
    logic [31:0] mdo;
    logic        gd;
  } bus_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  ack_t ackq[$];
  bus_t busq[$];
  bus_t mon_cur = '0;
  logic mon_prev = 1'b0;
  logic [31:0] exp_ddt = 32'h0;

  logic        hang = 1'b0;
  logic        force_ack = 1'b0;
  int          mem_wait = 0;
  int          bcnt = 0;
  logic [31:0] mem_rdata = 32'h0;

  mem_arbiter_if mif();

  mem_arbiter #(.TIMEOUT(15), .CW(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (mif)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic void push_bus(input logic d, input logic [31:0] mad, input logic mw,
                                   input logic [1:0] sz, input logic [31:0] mdo);
    busq.push_back('{mad: mad, mw: mw, sz: sz, mdo: mdo, gd: d});
  endfunction

  function automatic void push_ack(input logic d, input logic [31:0] data, input logic err);
    ackq.push_back('{d: d, data: data, err: err});
  endfunction

  // Waits for either ack, counting cycles spent with MREQ_m high
  task automatic wait_ack(input string nm, input int limit, output int at, output int nb);
    at = -1;
    nb = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (mif.MREQ_m) nb++;
      if (!mif.ACKI_n || !mif.ACKD_n) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      checks++;
      errors++;
      $display("FAIL %s: no ack within %0d cycles", nm, limit);
    end
  endtask

  // Memory model: acks after mem_wait high cycles of MREQ_m unless hung
  initial begin
    mif.MACK_n = 1'b1;
    mif.MDI    = 32'h0;
    forever begin
      @(negedge clk);
      if (force_ack) begin
        mif.MACK_n = 1'b0;
      end else if (mif.MREQ_m && !hang) begin
        mif.MACK_n = (bcnt == mem_wait) ? 1'b0 : 1'b1;
        bcnt++;
      end else begin
        mif.MACK_n = 1'b1;
        if (!mif.MREQ_m) bcnt = 0;
      end
      mif.MDI = mem_rdata;
    end
  end

  // Monitor: bus-phase starts and acks are popped against the scoreboard
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (mif.MREQ_m && !mon_prev) begin
        if (busq.size() == 0) begin
          chk("bus_unexpected", 32'(mif.MREQ_m), 32'h0);
        end else begin
          mon_cur = busq.pop_front();
          chk("MAD", mif.MAD, mon_cur.mad);
          chk("MWRITE", 32'(mif.MWRITE), 32'(mon_cur.mw));
          chk("MSIZE", 32'(mif.MSIZE), 32'(mon_cur.sz));
          chk("MDO", mif.MDO, mon_cur.mdo);
          chk("gnt_d_bus", 32'(mif.gnt_d), 32'(mon_cur.gd));
        end
      end else if (mif.MREQ_m) begin
        chk("MAD_hold", mif.MAD, mon_cur.mad);
        chk("MDO_hold", mif.MDO, mon_cur.mdo);
        chk("MWRITE_hold", 32'(mif.MWRITE), 32'(mon_cur.mw));
      end
      if (!mif.ACKI_n || !mif.ACKD_n) begin
        chk("one_ack", 32'(mif.ACKI_n ^ mif.ACKD_n), 32'h1);
        if (ackq.size() == 0) begin
          chk("ack_unexpected", 32'(mif.ACKI_n & mif.ACKD_n), 32'h1);
        end else begin
          ack_t e;
          e = ackq.pop_front();
          chk("ack_side", 32'(!mif.ACKD_n), 32'(e.d));
          chk("ack_data", e.d ? mif.DDT_r : mif.IDT, e.data);
          chk("ack_bus_err", 32'(mif.bus_err), 32'(e.err));
          chk("gnt_d_ack", 32'(mif.gnt_d), 32'(e.d));
        end
      end else if (mif.bus_err) begin
        chk("bus_err_stray", 32'(mif.bus_err), 32'h0);
      end
    end
    mon_prev = mif.MREQ_m;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int at, nb, t0, last;
    mif.IREQ  = 1'b0;
    mif.IAD   = 32'h0;
    mif.MREQ  = 1'b0;
    mif.WRITE = 1'b0;
    mif.SIZE  = 2'b00;
    mif.DAD   = 32'h0;
    mif.DDT_w = 32'h0;

    repeat (2) @(negedge clk);
    chk("rst_MREQ_m", 32'(mif.MREQ_m), 32'h0);
    chk("rst_ACKI_n", 32'(mif.ACKI_n), 32'h1);
    chk("rst_ACKD_n", 32'(mif.ACKD_n), 32'h1);
    chk("rst_MAD", mif.MAD, 32'h0);
    chk("rst_MDO", mif.MDO, 32'h0);
    chk("rst_MSIZE", 32'(mif.MSIZE), 32'h0);
    chk("rst_MWRITE", 32'(mif.MWRITE), 32'h0);
    chk("rst_IDT", mif.IDT, 32'h0);
    chk("rst_DDT_r", mif.DDT_r, 32'h0);
    chk("rst_gnt_d", 32'(mif.gnt_d), 32'h0);
    chk("rst_bus_err", 32'(mif.bus_err), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset asserted in the middle of a hung fetch
    hang = 1'b1;
    mif.IREQ = 1'b1;
    mif.IAD  = 32'h0000_0200;
    push_bus(1'b0, 32'h200, 1'b0, 2'b10, 32'h0);
    @(negedge clk);
    chk("abort_pre_MREQ_m", 32'(mif.MREQ_m), 32'h1);
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_MREQ_m", 32'(mif.MREQ_m), 32'h0);
    chk("abort_ACKI_n", 32'(mif.ACKI_n), 32'h1);
    chk("abort_ACKD_n", 32'(mif.ACKD_n), 32'h1);
    mif.IREQ = 1'b0;
    hang = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_idle_MREQ_m", 32'(mif.MREQ_m), 32'h0);
    chk("abort_idle_gnt_d", 32'(mif.gnt_d), 32'h0);
    exp_ddt = 32'h0;

    // Tie with both sides held: data first after reset, then alternating
    mem_rdata = 32'h1234_5678;
    mif.IAD   = 32'h0000_0080;
    mif.DAD   = 32'h0000_0300;
    mif.SIZE  = 2'b10;
    mif.WRITE = 1'b0;
    mif.DDT_w = 32'hDEAD_BEEF;
    for (int k = 0; k < 4; k++) begin
      logic d;
      d = (k % 2 == 0);
      push_bus(d, d ? 32'h300 : 32'h80, 1'b0, 2'b10, d ? 32'hDEAD_BEEF : 32'h0);
      push_ack(d, 32'h1234_5678, 1'b0);
    end
    t0 = cyc;
    last = cyc;
    mif.IREQ = 1'b1;
    mif.MREQ = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_ack("tie_ack", 10, at, nb);
      if (k == 0) chk("tie_first_latency", 32'(at - t0), 32'd2);
      else        chk("tie_spacing", 32'(at - last), 32'd3);
      last = at;
    end
    mif.IREQ = 1'b0;
    mif.MREQ = 1'b0;
    exp_ddt = 32'h1234_5678;

    // Single fetch with zero wait states
    @(negedge clk);
    mem_rdata = 32'h8C22_0004;
    mif.IAD = 32'h0000_0040;
    push_bus(1'b0, 32'h40, 1'b0, 2'b10, 32'h0);
    push_ack(1'b0, 32'h8C22_0004, 1'b0);
    mif.IREQ = 1'b1;
    @(negedge clk);
    chk("fetch_c1_MAD", mif.MAD, 32'h40);
    chk("fetch_c1_MWRITE", 32'(mif.MWRITE), 32'h0);
    chk("fetch_c1_MREQ_m", 32'(mif.MREQ_m), 32'h1);
    @(negedge clk);
    chk("fetch_c2_ACKI_n", 32'(mif.ACKI_n), 32'h0);
    chk("fetch_c2_IDT", mif.IDT, 32'h8C22_0004);
    chk("fetch_c2_MREQ_m", 32'(mif.MREQ_m), 32'h0);
    mif.IREQ = 1'b0;

    // Halfword store with four wait states
    @(negedge clk);
    mem_wait  = 4;
    mif.MREQ  = 1'b1;
    mif.WRITE = 1'b1;
    mif.SIZE  = 2'b01;
    mif.DAD   = 32'h0000_0100;
    mif.DDT_w = 32'h0000_BEEF;
    push_bus(1'b1, 32'h100, 1'b1, 2'b01, 32'h0000_BEEF);
    push_ack(1'b1, exp_ddt, 1'b0);
    wait_ack("store_ack", 30, at, nb);
    chk("store_bus_cycles", 32'(nb), 32'd5);
    mif.MREQ  = 1'b0;
    mif.WRITE = 1'b0;
    mem_wait  = 0;

    // Load that never gets MACK_n: forced error completion
    @(negedge clk);
    hang     = 1'b1;
    mif.MREQ = 1'b1;
    mif.SIZE = 2'b10;
    mif.DAD  = 32'h0000_0400;
    push_bus(1'b1, 32'h400, 1'b0, 2'b10, 32'h0000_BEEF);
    push_ack(1'b1, 32'h0, 1'b1);
    exp_ddt = 32'h0;
    wait_ack("timeout_ack", 40, at, nb);
    chk("timeout_bus_cycles", 32'(nb), 32'd15);
    mif.MREQ = 1'b0;
    hang = 1'b0;
    force_ack = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("late_MREQ_m", 32'(mif.MREQ_m), 32'h0);
      chk("late_ACKD_n", 32'(mif.ACKD_n), 32'h1);
    end
    force_ack = 1'b0;

    // Fetch withdrawn mid-transfer, pending load granted right after
    @(negedge clk);
    mem_wait  = 3;
    mem_rdata = 32'hCAFE_0001;
    mif.IAD   = 32'h0000_0500;
    mif.DAD   = 32'h0000_0600;
    push_bus(1'b0, 32'h500, 1'b0, 2'b10, 32'h0);
    push_ack(1'b0, 32'hCAFE_0001, 1'b0);
    push_bus(1'b1, 32'h600, 1'b0, 2'b10, 32'h0000_BEEF);
    push_ack(1'b1, 32'hCAFE_0001, 1'b0);
    mif.IREQ = 1'b1;
    mif.MREQ = 1'b1;
    @(negedge clk);
    @(negedge clk);
    mif.IREQ = 1'b0;
    wait_ack("withdraw_i_ack", 20, at, nb);
    chk("withdraw_ACKI_n", 32'(mif.ACKI_n), 32'h0);
    @(negedge clk);
    chk("withdraw_idle_MREQ_m", 32'(mif.MREQ_m), 32'h0);
    @(negedge clk);
    chk("withdraw_grant_MREQ_m", 32'(mif.MREQ_m), 32'h1);
    chk("withdraw_grant_gnt_d", 32'(mif.gnt_d), 32'h1);
    wait_ack("withdraw_d_ack", 20, at, nb);
    mif.MREQ = 1'b0;
    mem_wait = 0;

    repeat (3) @(negedge clk);
    chk("ackq_drained", 32'(ackq.size()), 32'h0);
    chk("busq_drained", 32'(busq.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
